reg_file_param: RTL and testbench

Parametrised two-read/one-write register file for the datapath, successor to the fixed 64x32 register file. It keeps the registered-read timing the datapath expects and adds four things: configurable width and depth, optional same-cycle write-to-read bypass, an optional hardwired zero register, and a post-reset clear sequencer with a `Ready` flag. It sits between decode (addresses) and execute (operands), and is written from writeback.

---
 rtl/reg_file_param.sv | 111 +++++++++++
 tb/tb_reg_file_param.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Parametrised 2R/1W register file: registered reads, optional write bypass and
// hardwired zero entry, with a post-reset clear sweep that gates Ready.

module rf_rd_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              run,
  input  logic              ReadEn,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [ADDR_W-1:0] RD,
  input  logic [DATA_W-1:0] arr_data,
  input  logic [DATA_W-1:0] DataIN,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] sel;

  // Zero entry outranks bypass, which outranks the pre-edge array word.
  always_comb begin
    sel = arr_data;
    if (ZERO_REG != 0 && raddr == '0)                   sel = '0;
    else if (BYPASS != 0 && RegWrite && raddr == RD)    sel = DataIN;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)            rdata <= '0;
    else if (run && ReadEn)  rdata <= sel;
  end
endmodule

module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              RegWrite,
  input  logic              ReadEn,
  input  logic [ADDR_W-1:0] RS,
  input  logic [ADDR_W-1:0] RT,
  input  logic [ADDR_W-1:0] RD,
  input  logic [DATA_W-1:0] DataIN,
  output logic [DATA_W-1:0] rs_Reg,
  output logic [DATA_W-1:0] rt_Reg,
  output logic              Ready
);
  localparam int DEPTH  = 2**ADDR_W;
  localparam int NUM_RD = 2;
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr;
  logic              run, wr_en;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [NUM_RD-1:0][ADDR_W-1:0] raddr;
  logic [NUM_RD-1:0][DATA_W-1:0] arr_data;
  logic [NUM_RD-1:0][DATA_W-1:0] rdata;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= CLEAR;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_ptr == LAST) state_nxt = RUN;
  end

  always_comb begin
    run   = (state == RUN);
    Ready = run;
    wr_en = run && RegWrite && !(ZERO_REG != 0 && RD == '0);
  end

  // Pointer saturates on the last entry; it is only reused after a reset.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)                           clr_ptr <= '0;
    else if (state == CLEAR && clr_ptr != LAST) clr_ptr <= clr_ptr + 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (state == CLEAR) mem[clr_ptr] <= '0;
    else if (wr_en)     mem[RD]      <= DataIN;
  end

  assign raddr = {RT, RS};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign arr_data[p] = mem[raddr[p]];
    rf_rd_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) u_port (
      .Clock(Clock), .Reset_n(Reset_n), .run(run), .ReadEn(ReadEn),
      .RegWrite(RegWrite), .raddr(raddr[p]), .RD(RD),
      .arr_data(arr_data[p]), .DataIN(DataIN), .rdata(rdata[p])
    );
  end

  assign rs_Reg = rdata[0];
  assign rt_Reg = rdata[1];
endmodule

// File: tb/tb_reg_file_param.sv
// Drives three configurations (bypass / no bypass / zero-reg) in lockstep and
// compares each against an array model built from the read/write rules.

module tb_reg_file_param;
  localparam int NC = 3;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we, re;
  logic [5:0]  rs, rt, rd;
  logic [31:0] din;
  logic [31:0] rs_q [NC];
  logic [31:0] rt_q [NC];
  logic        rdy  [NC];

  int checks = 0;
  int errors = 0;

  bit          byp [NC] = '{1'b1, 1'b0, 1'b1};
  bit          zr  [NC] = '{1'b0, 1'b0, 1'b1};
  logic [31:0] mem_m  [NC][DEPTH];
  logic [31:0] exp_rs [NC];
  logic [31:0] exp_rt [NC];

  always #5 clk = ~clk;

  reg_file_param #(.BYPASS(1), .ZERO_REG(0)) u_c0 (
    .Clock(clk), .Reset_n(rst_n), .RegWrite(we), .ReadEn(re), .RS(rs), .RT(rt),
    .RD(rd), .DataIN(din), .rs_Reg(rs_q[0]), .rt_Reg(rt_q[0]), .Ready(rdy[0]));
  reg_file_param #(.BYPASS(0), .ZERO_REG(0)) u_c1 (
    .Clock(clk), .Reset_n(rst_n), .RegWrite(we), .ReadEn(re), .RS(rs), .RT(rt),
    .RD(rd), .DataIN(din), .rs_Reg(rs_q[1]), .rt_Reg(rt_q[1]), .Ready(rdy[1]));
  reg_file_param #(.BYPASS(1), .ZERO_REG(1)) u_c2 (
    .Clock(clk), .Reset_n(rst_n), .RegWrite(we), .ReadEn(re), .RS(rs), .RT(rt),
    .RD(rd), .DataIN(din), .rs_Reg(rs_q[2]), .rt_Reg(rt_q[2]), .Ready(rdy[2]));

  task automatic check(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cfg%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_m(input int k, input logic [5:0] a);
    if (zr[k] && a == 6'd0)            return 32'd0;
    if (byp[k] && we && a == rd)       return din;
    return mem_m[k][a];
  endfunction

  task automatic check_all(input string tag);
    for (int k = 0; k < NC; k++) begin
      check({tag, ".rs"}, k, rs_q[k], exp_rs[k]);
      check({tag, ".rt"}, k, rt_q[k], exp_rt[k]);
    end
  endtask

  // One RUN cycle: drive at negedge, predict, apply edge, compare after it.
  task automatic step(input string tag, input logic w, input logic r,
                      input logic [5:0] a, input logic [5:0] b,
                      input logic [5:0] d, input logic [31:0] v);
    @(negedge clk);
    we = w; re = r; rs = a; rt = b; rd = d; din = v;
    for (int k = 0; k < NC; k++) begin
      if (r) begin
        exp_rs[k] = rd_m(k, a);
        exp_rt[k] = rd_m(k, b);
      end
      if (w && !(zr[k] && d == 6'd0)) mem_m[k][d] = v;
    end
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic reset_now(input string tag);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NC; k++) begin
      exp_rs[k] = '0; exp_rt[k] = '0;
      check({tag, ".rdy"}, k, {31'd0, rdy[k]}, 32'd0);
    end
    check_all(tag);
  endtask

  // Release reset and count edges; Ready must rise exactly on edge stop==DEPTH.
  task automatic run_clear(input string tag, input int stop);
    @(negedge clk);
    rst_n = 1'b1;
    we = 1'b1; re = 1'b1; rd = 6'd5; rs = 6'd5; rt = 6'd5; din = 32'hDEADBEEF;
    for (int e = 1; e <= stop; e++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NC; k++)
        check({tag, ".rdy"}, k, {31'd0, rdy[k]}, {31'd0, e == DEPTH});
      check_all(tag);
    end
    if (stop == DEPTH)
      for (int k = 0; k < NC; k++)
        for (int i = 0; i < DEPTH; i++) mem_m[k][i] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    we = 0; re = 0; rs = 0; rt = 0; rd = 0; din = 0;
    reset_now("por");
    #12;
    run_clear("clear", DEPTH);

    // Write during clear must not have landed; every entry reads 0.
    step("post_clr5", 1'b0, 1'b1, 6'd5, 6'd5, 6'd0, 32'd0);
    for (int i = 0; i < DEPTH; i += 2)
      step("sweep", 1'b0, 1'b1, 6'(i), 6'(i + 1), 6'd0, 32'd0);

    step("wr7",   1'b1, 1'b0, 6'd0, 6'd0, 6'd7, 32'h12345678);
    step("rd7",   1'b0, 1'b1, 6'd7, 6'd7, 6'd0, 32'd0);

    step("pre9",  1'b1, 1'b0, 6'd0, 6'd0, 6'd9, 32'h11);
    step("byp9",  1'b1, 1'b1, 6'd9, 6'd9, 6'd9, 32'hA5A5A5A5);
    step("rd9",   1'b0, 1'b1, 6'd9, 6'd7, 6'd0, 32'd0);

    step("zr_wr", 1'b1, 1'b1, 6'd0, 6'd0, 6'd0, 32'hFFFFFFFF);
    step("zr_rd", 1'b0, 1'b1, 6'd0, 6'd0, 6'd0, 32'd0);

    step("ld55",  1'b1, 1'b0, 6'd0, 6'd0, 6'd3, 32'h55);
    step("rd55",  1'b0, 1'b1, 6'd3, 6'd3, 6'd0, 32'd0);
    step("hold1", 1'b1, 1'b0, 6'd3, 6'd3, 6'd3, 32'h99);
    step("hold2", 1'b0, 1'b0, 6'd4, 6'd8, 6'd0, 32'd0);
    step("rel",   1'b0, 1'b1, 6'd3, 6'd3, 6'd0, 32'd0);

    for (int n = 0; n < 300; n++)
      step("rand", 1'($urandom), 1'($urandom_range(0, 3) != 0),
           6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)),
           6'($urandom_range(0, 15)), $urandom);

    // Asynchronous reset mid-run, away from any clock edge.
    @(negedge clk); #2;
    reset_now("rst_run");
    #10;
    run_clear("reclear", DEPTH);
    step("after_re", 1'b0, 1'b1, 6'd7, 6'd9, 6'd0, 32'd0);

    // Abort the clear at edge 30; the full sweep must restart.
    @(negedge clk); #2;
    reset_now("rst_a");
    #10;
    run_clear("clr30", 30);
    @(negedge clk); #2;
    reset_now("rst_b");
    #10;
    run_clear("clr_full", DEPTH);

    for (int n = 0; n < 100; n++)
      step("rand2", 1'($urandom), 1'($urandom_range(0, 3) != 0),
           6'($urandom), 6'($urandom), 6'($urandom_range(0, 7)), $urandom);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
